// File: rtl/adc_tpg_if.sv
// Sample-bus and configuration bundle between the ADC test pattern generator and its consumer.
// The master side is the generator: it takes enable/config and drives the packed sample bus.
interface adc_tpg_if #(
    parameter int ADC_DATA_WIDTH = 8,
    parameter int LANES          = 4,
    parameter int CNT_WIDTH      = 18
);
    logic                             en;
    logic                             cfg_load;
    logic [1:0]                       cfg_mode;
    logic [ADC_DATA_WIDTH-1:0]        cfg_base;
    logic [ADC_DATA_WIDTH-1:0]        cfg_peak_val;
    logic [7:0]                       cfg_peak_lane;
    logic [CNT_WIDTH-1:0]             cfg_peak_offset;
    logic [ADC_DATA_WIDTH*LANES-1:0]  adc_all_bit_o;
    logic                             window_start_o;
    logic [ADC_DATA_WIDTH-1:0]        expected_max_o;
    logic                             expected_max_valid_o;

    modport master (
        input  en, cfg_load, cfg_mode, cfg_base, cfg_peak_val, cfg_peak_lane, cfg_peak_offset,
        output adc_all_bit_o, window_start_o, expected_max_o, expected_max_valid_o
    );

    modport slave (
        output en, cfg_load, cfg_mode, cfg_base, cfg_peak_val, cfg_peak_lane, cfg_peak_offset,
        input  adc_all_bit_o, window_start_o, expected_max_o, expected_max_valid_o
    );
endinterface

// File: rtl/adc_test_pattern_gen.sv
// Synthetic multi-lane ADC source: CONST/RAMP/PEAK/PRBS patterns in fixed windows, plus the
// true per-window maximum so downstream peak detectors can be checked in-system.
module adc_test_pattern_gen #(
    parameter int ADC_DATA_WIDTH = 8,
    parameter int LANES          = 4,
    parameter int WINDOW_LEN     = 150000,
    parameter int CNT_WIDTH      = 18
) (
    input  logic      clk,
    input  logic      rst,
    adc_tpg_if.master bus
);
    localparam int                   W         = ADC_DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] LAST_N    = CNT_WIDTH'(WINDOW_LEN - 1);
    localparam logic [15:0]          LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        MODE_CONST = 2'd0,
        MODE_RAMP  = 2'd1,
        MODE_PEAK  = 2'd2,
        MODE_PRBS  = 2'd3
    } mode_e;

    typedef struct packed {
        mode_e                mode;
        logic [W-1:0]         base;
        logic [W-1:0]         peak_val;
        logic [7:0]           peak_lane;
        logic [CNT_WIDTH-1:0] peak_offset;
    } cfg_t;

    cfg_t                 act_q, act_d, pend_q, pend_d, cfg_in, cfg_eff;
    logic                 pend_vld_q, pend_vld_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [15:0]          lfsr_q, lfsr_d;
    logic [W-1:0]         run_max_q, run_max_d;
    logic                 last_q, last_d;
    logic [W*LANES-1:0]   data_q, data_d;
    logic                 ws_q, ws_d;
    logic [W-1:0]         max_q, max_d;
    logic                 valid_q, valid_d;
    logic [W-1:0]         samp [LANES];
    logic [W-1:0]         samp_max;
    logic                 at_start;

    // Sample generation for the cycle about to be emitted (cnt_q).
    always_comb begin
        // NOTE: every comb output gets a default up front so no path can infer a latch.
        samp     = '{default: '0};
        samp_max = '0;
        cfg_in   = '{mode: mode_e'(bus.cfg_mode), base: bus.cfg_base, peak_val: bus.cfg_peak_val,
                     peak_lane: bus.cfg_peak_lane, peak_offset: bus.cfg_peak_offset};
        at_start = (cnt_q == '0);
        // Pending config takes effect on the very sample that opens a window.
        cfg_eff  = (at_start && pend_vld_q) ? pend_q : act_q;
        for (int k = 0; k < LANES; k++) begin
            case (cfg_eff.mode)
                MODE_RAMP: samp[k] = W'(int'(cnt_q) * LANES + k);
                MODE_PEAK: samp[k] = (int'(cfg_eff.peak_lane) == k && cnt_q == cfg_eff.peak_offset)
                                     ? cfg_eff.peak_val : cfg_eff.base;
                MODE_PRBS: samp[k] = lfsr_q[W-1:0] ^ W'(k * 'h35);
                default:   samp[k] = cfg_eff.base;
            endcase
            if (samp[k] > samp_max) samp_max = samp[k];
        end
    end

    always_comb begin
        act_d      = act_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        cnt_d      = '0;
        lfsr_d     = lfsr_q;
        run_max_d  = '0;
        last_d     = 1'b0;
        data_d     = '0;
        ws_d       = 1'b0;
        valid_d    = last_q;
        max_d      = last_q ? run_max_q : max_q;

        if (bus.en && at_start && pend_vld_q) pend_vld_d = 1'b0;
        // A load in the boundary clk lands in pending after the consume, so it waits a window.
        if (bus.cfg_load) begin
            pend_d     = cfg_in;
            pend_vld_d = 1'b1;
        end

        if (bus.en) begin
            act_d  = cfg_eff;
            ws_d   = at_start;
            cnt_d  = (cnt_q == LAST_N) ? '0 : cnt_q + 1'b1;
            last_d = (cnt_q == LAST_N);
            lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
            for (int k = 0; k < LANES; k++) data_d[k*W +: W] = samp[k];
            run_max_d = (at_start || samp_max > run_max_q) ? samp_max : run_max_q;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so all update together at the edge.
        if (rst) begin
            act_q      <= cfg_t'('0);
            pend_q     <= cfg_t'('0);
            pend_vld_q <= 1'b0;
            cnt_q      <= '0;
            lfsr_q     <= LFSR_SEED;
            run_max_q  <= '0;
            last_q     <= 1'b0;
            data_q     <= '0;
            ws_q       <= 1'b0;
            max_q      <= '0;
            valid_q    <= 1'b0;
        end else begin
            act_q      <= act_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            cnt_q      <= cnt_d;
            lfsr_q     <= lfsr_d;
            run_max_q  <= run_max_d;
            last_q     <= last_d;
            data_q     <= data_d;
            ws_q       <= ws_d;
            max_q      <= max_d;
            valid_q    <= valid_d;
        end
    end

    assign bus.adc_all_bit_o        = data_q;
    assign bus.window_start_o       = ws_q;
    assign bus.expected_max_o       = max_q;
    assign bus.expected_max_valid_o = valid_q;
endmodule

// File: tb/tb_adc_test_pattern_gen.sv
// Directed bench for adc_test_pattern_gen: table of single-window vectors plus hand-written
// sequences for config timing, enable drop, PRBS/reset and RAMP wrap on a 128-clk window.
module tb_adc_test_pattern_gen;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    adc_tpg_if #(.ADC_DATA_WIDTH(8), .LANES(4), .CNT_WIDTH(18)) bus ();
    adc_tpg_if #(.ADC_DATA_WIDTH(8), .LANES(4), .CNT_WIDTH(18)) bus2 ();

    adc_test_pattern_gen #(.ADC_DATA_WIDTH(8), .LANES(4), .WINDOW_LEN(16), .CNT_WIDTH(18))
        u_dut (.clk(clk), .rst(rst), .bus(bus));
    adc_test_pattern_gen #(.ADC_DATA_WIDTH(8), .LANES(4), .WINDOW_LEN(128), .CNT_WIDTH(18))
        u_dut_long (.clk(clk), .rst(rst), .bus(bus2));

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] base;
        logic [7:0] pval;
        logic [7:0] plane;
        int         poff;
        int         probe_n;
        int         probe_k;
        logic [7:0] probe_v;
        logic [7:0] exp_max;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    function automatic logic [31:0] model_word(input logic [1:0] mode, input logic [7:0] base,
                                               input logic [7:0] pval, input logic [7:0] plane,
                                               input int poff, input int n, input logic [15:0] lfsr);
        logic [31:0] w;
        logic [7:0]  v;
        w = '0;
        for (int k = 0; k < 4; k++) begin
            case (mode)
                2'd0:    v = base;
                2'd1:    v = 8'((n * 4 + k) % 256);
                2'd2:    v = (k == int'(plane) && n == poff) ? pval : base;
                default: v = lfsr[7:0] ^ 8'((k * 53) % 256);
            endcase
            w[k*8 +: 8] = v;
        end
        return w;
    endfunction

    function automatic logic [7:0] max_of(input logic [31:0] w);
        logic [7:0] m;
        m = '0;
        for (int k = 0; k < 4; k++) if (w[k*8 +: 8] > m) m = w[k*8 +: 8];
        return m;
    endfunction

    task automatic set_cfg(input logic [1:0] m, input logic [7:0] b, input logic [7:0] pv,
                           input logic [7:0] pl, input int po);
        bus.cfg_mode        = m;
        bus.cfg_base        = b;
        bus.cfg_peak_val    = pv;
        bus.cfg_peak_lane   = pl;
        bus.cfg_peak_offset = 18'(po);
        bus.cfg_load        = 1'b1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.en        = 1'b0;
        bus.cfg_load  = 1'b0;
        bus2.en       = 1'b0;
        bus2.cfg_load = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_w;
        logic [15:0] lfsr_m;
        logic [7:0]  mx;
        int          errs;

        vecs[0] = '{2'd0, 8'h40, 8'h00, 8'd0, 0,  3,  2, 8'h40, 8'h40};
        vecs[1] = '{2'd2, 8'h10, 8'hF0, 8'd3, 5,  5,  3, 8'hF0, 8'hF0};
        vecs[2] = '{2'd2, 8'h10, 8'hF0, 8'd4, 5,  5,  3, 8'h10, 8'h10};
        vecs[3] = '{2'd1, 8'h00, 8'h00, 8'd0, 0,  15, 3, 8'h3F, 8'h3F};
        vecs[4] = '{2'd2, 8'h10, 8'hF0, 8'd3, 20, 5,  3, 8'h10, 8'h10};
        vecs[5] = '{2'd2, 8'h10, 8'hF0, 8'd0, 0,  0,  0, 8'hF0, 8'hF0};
        vecs[6] = '{2'd2, 8'h10, 8'hF0, 8'd3, 15, 15, 3, 8'hF0, 8'hF0};

        bus.cfg_mode = '0; bus.cfg_base = '0; bus.cfg_peak_val = '0;
        bus.cfg_peak_lane = '0; bus.cfg_peak_offset = '0;
        bus2.cfg_mode = '0; bus2.cfg_base = '0; bus2.cfg_peak_val = '0;
        bus2.cfg_peak_lane = '0; bus2.cfg_peak_offset = '0;
        do_reset();

        check("reset data",  bus.adc_all_bit_o, 32'h0);
        check("reset ws",    bus.window_start_o, 32'h0);
        check("reset valid", bus.expected_max_valid_o, 32'h0);
        check("reset max",   bus.expected_max_o, 32'h0);

        // Table: one full window per vector, then the valid pulse.
        foreach (vecs[v]) begin
            do_reset();
            set_cfg(vecs[v].mode, vecs[v].base, vecs[v].pval, vecs[v].plane, vecs[v].poff);
            tick();
            bus.cfg_load = 1'b0;
            bus.en       = 1'b1;
            lfsr_m       = 16'hACE1;
            errs         = 0;
            for (int i = 0; i < 16; i++) begin
                tick();
                exp_w = model_word(vecs[v].mode, vecs[v].base, vecs[v].pval, vecs[v].plane,
                                   vecs[v].poff, i, lfsr_m);
                if (bus.adc_all_bit_o !== exp_w) errs++;
                if (bus.window_start_o !== (i == 0)) errs++;
                if (bus.expected_max_valid_o !== 1'b0) errs++;
                if (i == vecs[v].probe_n)
                    check($sformatf("vec%0d probe", v), bus.adc_all_bit_o[vecs[v].probe_k*8 +: 8],
                          vecs[v].probe_v);
                lfsr_m = lfsr_step(lfsr_m);
            end
            check($sformatf("vec%0d window errors", v), errs, 0);
            tick();
            check($sformatf("vec%0d valid", v), bus.expected_max_valid_o, 1);
            check($sformatf("vec%0d max", v), bus.expected_max_o, vecs[v].exp_max);
            bus.en = 1'b0;
        end

        // Mid-window loads, last load wins, load in the boundary clk waits one window.
        do_reset();
        set_cfg(2'd0, 8'h40, 8'h00, 8'd0, 0);
        tick();
        bus.cfg_load = 1'b0;
        bus.en       = 1'b1;
        errs         = 0;
        for (int i = 0; i <= 48; i++) begin
            if (i == 8)       set_cfg(2'd2, 8'h10, 8'hF0, 8'd3, 5);
            else if (i == 10) set_cfg(2'd2, 8'h10, 8'hE0, 8'd3, 5);
            else if (i == 16) set_cfg(2'd0, 8'h22, 8'h00, 8'd0, 0);
            tick();
            bus.cfg_load = 1'b0;
            case (i / 16)
                0:       exp_w = model_word(2'd0, 8'h40, 8'h00, 8'd0, 0, i % 16, 16'h0);
                1:       exp_w = model_word(2'd2, 8'h10, 8'hE0, 8'd3, 5, i % 16, 16'h0);
                default: exp_w = model_word(2'd0, 8'h22, 8'h00, 8'd0, 0, i % 16, 16'h0);
            endcase
            if (bus.adc_all_bit_o !== exp_w) errs++;
            if (bus.window_start_o !== (i % 16 == 0)) errs++;
            if (i == 16) begin
                check("cfg w0 valid", bus.expected_max_valid_o, 1);
                check("cfg w0 max", bus.expected_max_o, 8'h40);
            end else if (i == 32) begin
                check("cfg w1 valid", bus.expected_max_valid_o, 1);
                check("cfg w1 max", bus.expected_max_o, 8'hE0);
            end else if (i == 48) begin
                check("cfg w2 valid", bus.expected_max_valid_o, 1);
                check("cfg w2 max", bus.expected_max_o, 8'h22);
            end else if (bus.expected_max_valid_o !== 1'b0) errs++;
        end
        check("cfg sequence errors", errs, 0);
        bus.en = 1'b0;

        // Enable dropped at n=9: partial window abandoned, then a clean restart.
        do_reset();
        set_cfg(2'd0, 8'h40, 8'h00, 8'd0, 0);
        tick();
        bus.cfg_load = 1'b0;
        bus.en       = 1'b1;
        for (int i = 0; i < 26; i++) tick();
        check("en-drop max before", bus.expected_max_o, 8'h40);
        bus.en = 1'b0;
        set_cfg(2'd1, 8'h00, 8'h00, 8'd0, 0);
        tick();
        bus.cfg_load = 1'b0;
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.adc_all_bit_o !== 32'h0 || bus.window_start_o !== 1'b0) errs++;
            if (bus.expected_max_valid_o !== 1'b0) errs++;
            tick();
        end
        check("en-drop idle errors", errs, 0);
        check("en-drop max held", bus.expected_max_o, 8'h40);
        bus.en = 1'b1;
        tick();
        check("restart ws", bus.window_start_o, 1);
        check("restart data", bus.adc_all_bit_o, 32'h03020100);
        errs = 0;
        for (int i = 1; i < 16; i++) begin
            tick();
            if (bus.expected_max_valid_o !== 1'b0 || bus.window_start_o !== 1'b0) errs++;
        end
        check("restart window errors", errs, 0);
        tick();
        check("restart valid", bus.expected_max_valid_o, 1);
        check("restart max", bus.expected_max_o, 8'h3F);
        bus.en = 1'b0;

        // PRBS from reset, bench-model max, then reset mid-window reseeds the LFSR.
        do_reset();
        set_cfg(2'd3, 8'h00, 8'h00, 8'd0, 0);
        tick();
        bus.cfg_load = 1'b0;
        bus.en       = 1'b1;
        lfsr_m       = 16'hACE1;
        mx           = '0;
        errs         = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            exp_w = model_word(2'd3, 8'h00, 8'h00, 8'd0, 0, i, lfsr_m);
            if (bus.adc_all_bit_o !== exp_w) errs++;
            if (max_of(exp_w) > mx) mx = max_of(exp_w);
            if (i == 0) begin
                check("prbs lane0 first", bus.adc_all_bit_o[7:0], 8'hE1);
                check("prbs lane1 first", bus.adc_all_bit_o[15:8], 8'hD4);
            end
            lfsr_m = lfsr_step(lfsr_m);
        end
        check("prbs window errors", errs, 0);
        tick();
        check("prbs valid", bus.expected_max_valid_o, 1);
        check("prbs max", bus.expected_max_o, mx);
        for (int i = 0; i < 4; i++) tick();
        rst    = 1'b1;
        bus.en = 1'b0;
        tick();
        check("mid-rst data", bus.adc_all_bit_o, 32'h0);
        rst  = 1'b0;
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.expected_max_valid_o !== 1'b0) errs++;
        end
        check("mid-rst no pulse", errs, 0);
        check("mid-rst max cleared", bus.expected_max_o, 8'h00);
        set_cfg(2'd3, 8'h00, 8'h00, 8'd0, 0);
        tick();
        bus.cfg_load = 1'b0;
        bus.en       = 1'b1;
        tick();
        check("reseed lane0", bus.adc_all_bit_o[7:0], 8'hE1);
        bus.en = 1'b0;

        // RAMP wrap on a 128-clk window.
        bus2.cfg_mode = 2'd1;
        bus2.cfg_load = 1'b1;
        tick();
        bus2.cfg_load = 1'b0;
        bus2.en       = 1'b1;
        errs          = 0;
        for (int i = 0; i < 128; i++) begin
            tick();
            if (bus2.expected_max_valid_o !== 1'b0) errs++;
            if (i == 63) check("wrap n63 lane3", bus2.adc_all_bit_o[31:24], 8'hFF);
            if (i == 64) check("wrap n64 lane0", bus2.adc_all_bit_o[7:0], 8'h00);
        end
        check("wrap no early pulse", errs, 0);
        tick();
        check("wrap valid", bus2.expected_max_valid_o, 1);
        check("wrap max", bus2.expected_max_o, 8'hFF);
        bus2.en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
